// File: rtl/life_pkg.sv
// life_pkg: shared state type, frame timing constants and the B3/S23 rule for life_round.
package life_pkg;
    typedef enum logic {IDLE, RUN} state_t;
    localparam int FRAME_LEN = 11;
    localparam logic [3:0] SLOT_SELF = 4'd4;
    localparam logic [3:0] SLOT_LAST = 4'd8;
    localparam logic [3:0] CYC_CAPTURE = 4'd9;
    localparam logic [3:0] CYC_WRITE = 4'(FRAME_LEN - 1);
    function automatic int slot_dr(logic [3:0] k);
        return (k < 4'd3) ? -1 : (k < 4'd6) ? 0 : 1;
    endfunction
    function automatic int slot_dc(logic [3:0] k);
        return int'(k % 4'd3) - 1;
    endfunction
    function automatic logic life_next(logic self, logic [3:0] n);
        return (n == 4'd3) | (self & (n == 4'd2));
    endfunction
endpackage

// File: rtl/life_rule.sv
// life_rule: next state of one cell from its own state and its live-neighbour count.
module life_rule import life_pkg::*; (
    input  logic       self,
    input  logic [3:0] n,
    output logic       live
);
    assign live = life_next(self, n);
endmodule

// File: rtl/life_round.sv
// life_round: walks the grid once per evolution-flag change, reading each cell's
// neighbourhood over an 11-cycle frame and writing its next state.
module life_round import life_pkg::*; #(
    parameter int P_PARAM_M = 30,
    parameter int P_PARAM_N = 40,
    parameter int P_POS_W   = 12
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   global_evo_en,
    input  logic                   prev_status,
    output logic                   rden,
    output logic                   wden,
    output logic [2*P_POS_W-1:0]   round_read_pos,
    output logic [2*P_POS_W-1:0]   round_write_pos,
    output logic                   live
);
    localparam logic [P_POS_W-1:0] ROW_LAST = P_POS_W'(P_PARAM_M - 1);
    localparam logic [P_POS_W-1:0] COL_LAST = P_POS_W'(P_PARAM_N - 1);
    localparam logic [P_POS_W-1:0] ONE = P_POS_W'(1);
    state_t state, state_n;
    logic evo_q, rd_q, self_q, self_n, toggle, rden_n, wden_n, rule_live;
    logic [3:0] cyc, cyc_n, acc, acc_n;
    logic [P_POS_W-1:0] row, row_n, col, col_n;
    int nr, nc;
    assign toggle = global_evo_en != evo_q;
    always_comb begin
        state_n = state;
        cyc_n = cyc;
        row_n = row;
        col_n = col;
        if (toggle) begin
            state_n = RUN;
            cyc_n = '0;
            row_n = '0;
            col_n = '0;
        end else if (state == RUN) begin
            cyc_n = (cyc == CYC_WRITE) ? 4'd0 : cyc + 4'd1;
            if (cyc == CYC_WRITE) begin
                col_n = (col == COL_LAST) ? '0 : col + ONE;
                row_n = (col == COL_LAST) ? row + ONE : row;
                state_n = (col == COL_LAST && row == ROW_LAST) ? IDLE : RUN;
            end
        end
    end
    // Read data for the slot issued last cycle lands now; slot 4 is the cell itself.
    always_comb begin
        acc_n = acc;
        self_n = self_q;
        if (state == RUN && rd_q && cyc != 4'd0 && cyc <= CYC_CAPTURE) begin
            if (cyc == SLOT_SELF + 4'd1) self_n = prev_status;
            else acc_n = acc + {3'b0, prev_status};
        end
        if (cyc_n == 4'd0) begin
            acc_n = '0;
            self_n = 1'b0;
        end
    end
    always_comb begin
        nr = int'(row_n) + slot_dr(cyc_n);
        nc = int'(col_n) + slot_dc(cyc_n);
        rden_n = state_n == RUN && cyc_n <= SLOT_LAST && nr >= 0 && nr < P_PARAM_M
                 && nc >= 0 && nc < P_PARAM_N;
        wden_n = state_n == RUN && cyc_n == CYC_WRITE;
    end
    life_rule u_rule (.self(self_n), .n(acc_n), .live(rule_live));
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            evo_q <= 1'b0;
            rd_q <= 1'b0;
            self_q <= 1'b0;
            cyc <= '0;
            acc <= '0;
            row <= '0;
            col <= '0;
            rden <= 1'b0;
            wden <= 1'b0;
            round_read_pos <= '0;
            round_write_pos <= '0;
            live <= 1'b0;
        end else begin
            state <= state_n;
            evo_q <= global_evo_en;
            rd_q <= rden;
            self_q <= self_n;
            cyc <= cyc_n;
            acc <= acc_n;
            row <= row_n;
            col <= col_n;
            rden <= rden_n;
            wden <= wden_n;
            if (rden_n) round_read_pos <= {nr[P_POS_W-1:0], nc[P_POS_W-1:0]};
            if (wden_n) begin
                round_write_pos <= {row_n, col_n};
                live <= rule_live;
            end
        end
    end
endmodule

// File: tb/tb_life_round.sv
// tb_life_round: directed passes over a 5x5 grid with a 1-cycle read RAM model
// and a separate destination array fed by the write port.
module tb_life_round;
    logic clk = 1'b0, rst, evo, rdata = 1'b0;
    logic rden, wden, live;
    logic [23:0] read_pos, write_pos, last_w = '0;
    logic [24:0] src, dst;
    int rcnt = 0, wcnt = 0, ord_err = 0;
    int checks = 0, errors = 0;
    int last, fr, w0, r0, o0;
    logic [23:0] fa;

    life_round #(.P_PARAM_M(5), .P_PARAM_N(5), .P_POS_W(12)) dut (
        .clk(clk), .rst(rst), .global_evo_en(evo), .prev_status(rdata),
        .rden(rden), .wden(wden), .round_read_pos(read_pos),
        .round_write_pos(write_pos), .live(live)
    );

    always #5 clk = ~clk;

    function automatic int idx(logic [23:0] p);
        return int'(p[23:12]) * 5 + int'(p[11:0]);
    endfunction
    function automatic logic [23:0] succ(logic [23:0] p);
        return (p[11:0] == 12'd4) ? {p[23:12] + 12'd1, 12'd0} : {p[23:12], p[11:0] + 12'd1};
    endfunction
    function automatic logic [24:0] at(int r, int c);
        logic [24:0] g = '0;
        g[r * 5 + c] = 1'b1;
        return g;
    endfunction

    always @(posedge clk) begin
        if (rden) begin
            rdata <= src[idx(read_pos)];
            rcnt <= rcnt + 1;
        end
        if (wden) begin
            dst[idx(write_pos)] <= live;
            wcnt <= wcnt + 1;
            if (!(write_pos == 24'd0 || write_pos == succ(last_w))) ord_err <= ord_err + 1;
            last_w <= write_pos;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; i counts cycles after the edge that samples the toggle.
    task automatic run_pass(input logic v, input int ncyc, output int lw, output int f,
                            output logic [23:0] a);
        evo = v;
        lw = -1;
        f = -1;
        a = '0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (rden && f < 0) begin
                f = i;
                a = read_pos;
            end
            if (wden) lw = i;
        end
    endtask

    initial begin
        rst = 1'b1;
        evo = 1'b0;
        src = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        check("idle rden", 32'(rden), 32'd0);
        check("idle wden", 32'(wden), 32'd0);
        check("idle read_pos", 32'(read_pos), 32'd0);
        check("idle write_pos", 32'(write_pos), 32'd0);
        check("idle live", 32'(live), 32'd0);

        src = at(1, 2) | at(2, 2) | at(3, 2);
        w0 = wcnt; r0 = rcnt; o0 = ord_err;
        run_pass(1'b1, 290, last, fr, fa);
        check("blinker pass len", 32'(last + 1), 32'd275);
        check("blinker writes", 32'(wcnt - w0), 32'd25);
        check("blinker reads", 32'(rcnt - r0), 32'd169);
        check("blinker order", 32'(ord_err - o0), 32'd0);
        check("blinker result", 32'(dst), 32'(at(2, 1) | at(2, 2) | at(2, 3)));
        check("blinker last write pos", 32'(write_pos), 32'h004004);
        check("blinker end rden", 32'(rden), 32'd0);
        check("blinker end wden", 32'(wden), 32'd0);

        src = at(0, 0) | at(0, 1) | at(1, 0) | at(1, 1);
        w0 = wcnt; r0 = rcnt;
        run_pass(1'b0, 290, last, fr, fa);
        check("block pass len", 32'(last + 1), 32'd275);
        check("block writes", 32'(wcnt - w0), 32'd25);
        check("block reads", 32'(rcnt - r0), 32'd169);
        check("block result", 32'(dst), 32'(at(0, 0) | at(0, 1) | at(1, 0) | at(1, 1)));

        src = at(4, 4);
        w0 = wcnt;
        run_pass(1'b1, 290, last, fr, fa);
        check("single writes", 32'(wcnt - w0), 32'd25);
        check("single result", 32'(dst), 32'd0);
        check("first rden cycle", 32'(fr), 32'd4);
        check("first rden addr", 32'(fa), 32'd0);

        src = at(1, 2) | at(2, 2) | at(3, 2);
        w0 = wcnt;
        evo = 1'b0;
        repeat (109) @(negedge clk);
        check("writes before abort", 32'(wcnt - w0), 32'd9);
        src = at(2, 1) | at(2, 2) | at(2, 3);
        w0 = wcnt; o0 = ord_err;
        run_pass(1'b1, 290, last, fr, fa);
        check("restart pass len", 32'(last + 1), 32'd275);
        check("restart writes", 32'(wcnt - w0), 32'd25);
        check("restart order", 32'(ord_err - o0), 32'd0);
        check("restart result", 32'(dst), 32'(at(1, 2) | at(2, 2) | at(3, 2)));

        evo = 1'b0;
        repeat (51) @(negedge clk);
        rst = 1'b1;
        #1;
        check("reset rden", 32'(rden), 32'd0);
        check("reset wden", 32'(wden), 32'd0);
        check("reset read_pos", 32'(read_pos), 32'd0);
        check("reset write_pos", 32'(write_pos), 32'd0);
        check("reset live", 32'(live), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        w0 = wcnt;
        repeat (300) @(negedge clk);
        check("writes after reset", 32'(wcnt - w0), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
